// File: rtl/qsys_system_onchip_memory3.sv
// qsys_system_onchip_memory3: Avalon-MM on-chip RAM with pipelined reads.
// Define ONCHIP_MEM3_CLEAR_EN to zero the whole array after every reset.
module qsys_system_onchip_memory3 #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 10,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = "qsys_system_onchip_memory3.hex"
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W/8-1:0] byteenable,
   input  logic                chipselect,
   input  logic                read,
   input  logic                write,
   input  logic [DATA_W-1:0]   writedata,
   input  logic                clken,
   input  logic                reset_req,
   output logic                waitrequest,
   output logic [DATA_W-1:0]   readdata,
   output logic                readdatavalid
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int BE_W  = DATA_W/8;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic              clearing;
   logic              req_ok;
   logic              wr_acc;
   logic              rd_acc;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] out_q;
   logic              out_v;
`ifdef ONCHIP_MEM3_CLEAR_EN
   logic [ADDR_W-1:0] clr_addr;
`endif

   (* ram_init_file = INIT_FILE *)
   logic [DATA_W-1:0] mem [DEPTH];

   assign clearing    = (state == CLEAR);
   assign waitrequest = ~clken | reset_req | clearing;
   assign req_ok      = chipselect & ~waitrequest;
   assign wr_acc      = req_ok & write;
   // a combined read+write is a write only
   assign rd_acc      = req_ok & read & ~write;

   always_ff @(posedge clk) begin
      if (clken) begin
`ifdef ONCHIP_MEM3_CLEAR_EN
         if (clearing)
            mem[clr_addr] <= '0;
`endif
         if (wr_acc)
            for (int i = 0; i < BE_W; i++)
               if (byteenable[i])
                  mem[address][8*i +: 8] <= writedata[8*i +: 8];
         ram_q <= mem[address];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CLEAR;
`ifdef ONCHIP_MEM3_CLEAR_EN
         clr_addr <= '0;
`endif
      end else begin
`ifdef ONCHIP_MEM3_CLEAR_EN
         if (clearing && clken) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr)
               state <= IDLE;
         end
`else
         state <= IDLE;
`endif
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic v1;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               v1    <= 1'b0;
               out_v <= 1'b0;
               out_q <= '0;
            end else if (clken) begin
               v1    <= rd_acc;
               out_v <= v1;
               out_q <= ram_q;
            end
         end
      end else begin : g_lat1
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               out_v <= 1'b0;
            else if (clken)
               out_v <= rd_acc;
         end
         assign out_q = ram_q;
      end
   endgenerate

   // a stalled response is only presented once clken lets it transfer
   assign readdatavalid = out_v & clken;
   assign readdata      = readdatavalid ? out_q : '0;

endmodule

// File: tb/tb_qsys_system_onchip_memory3.sv
// tb_qsys_system_onchip_memory3: scoreboard bench, latency 1 and 2 copies.
// Build with ONCHIP_MEM3_CLEAR_EN to exercise the clear engine.
module tb_qsys_system_onchip_memory3;

`ifdef ONCHIP_MEM3_CLEAR_EN
   localparam int          AW      = 4;
   localparam int          CLR_CYC = 16;
   localparam logic [31:0] EXP9    = 32'h0;
`else
   localparam int          AW      = 10;
   localparam int          CLR_CYC = 1;
   localparam logic [31:0] EXP9    = 32'hCAFEF00D;
`endif

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] address = '0;
   logic [3:0]    byteenable = '0;
   logic          chipselect = 1'b0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [31:0]   writedata = '0;
   logic          clken = 1'b1;
   logic          reset_req = 1'b0;
   logic          wait1, wait2;
   logic          rdv1, rdv2;
   logic [31:0]   rdata1, rdata2;

   exp_t q1[$];
   exp_t q2[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   qsys_system_onchip_memory3 #(
      .DATA_W(32), .ADDR_W(AW), .READ_LATENCY(1)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address),
      .byteenable(byteenable), .chipselect(chipselect),
      .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req),
      .waitrequest(wait1), .readdata(rdata1),
      .readdatavalid(rdv1)
   );

   qsys_system_onchip_memory3 #(
      .DATA_W(32), .ADDR_W(AW), .READ_LATENCY(2)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address),
      .byteenable(byteenable), .chipselect(chipselect),
      .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req),
      .waitrequest(wait2), .readdata(rdata2),
      .readdatavalid(rdv2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rdv1) begin
         if (q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rdv1 unexpected: data %0h cycle %0d",
                     rdata1, cyc);
         end else begin
            e = q1.pop_front();
            chk("rdata1", rdata1, e.d);
            chk("rdv1 cycle", cyc, e.c);
         end
      end else begin
         chk("rdata1 idle", rdata1, 32'h0);
      end
      if (rdv2) begin
         if (q2.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rdv2 unexpected: data %0h cycle %0d",
                     rdata2, cyc);
         end else begin
            e = q2.pop_front();
            chk("rdata2", rdata2, e.d);
            chk("rdv2 cycle", cyc, e.c);
         end
      end else begin
         chk("rdata2 idle", rdata2, 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
   endtask

   task automatic push(input logic [31:0] d, input int stall);
      exp_t e;
      e.d = d;
      e.c = cyc + 1 + stall;
      q1.push_back(e);
      e.c = cyc + 2 + stall;
      q2.push_back(e);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [3:0] be);
      chipselect = 1'b1;
      write      = 1'b1;
      read       = 1'b0;
      address    = a;
      writedata  = d;
      byteenable = be;
      step();
      idle();
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      read       = 1'b1;
      write      = 1'b0;
      address    = a;
      push(d, 0);
      step();
      idle();
   endtask

   task automatic count_wait(input string name);
      int n = 0;
      @(negedge clk);
      while (wait1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk(name, n, CLR_CYC);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst waitrequest", wait1, 1'b1);
      chk("rst rdv1", rdv1, 1'b0);
      chk("rst rdv2", rdv2, 1'b0);
      chk("rst readdata", rdata1, 32'h0);
      step();
      reset_n = 1'b1;
      count_wait("wait after reset");
      step();

      wr(5, 32'hDEADBEEF, 4'hF);
      rd(5, 32'hDEADBEEF);
      wr(5, 32'h12345678, 4'hA);
      rd(5, 32'h12AD56EF);

      wr(7, 32'h11223344, 4'hF);
      wr(7, 32'hAABBCCDD, 4'h5);
      rd(7, 32'h11BB33DD);

      wr(1, 32'h10000001, 4'hF);
      wr(2, 32'h20000002, 4'hF);
      wr(3, 32'h30000003, 4'hF);
      rd(1, 32'h10000001);
      rd(2, 32'h20000002);
      rd(3, 32'h30000003);

      chipselect = 1'b1;
      read       = 1'b1;
      write      = 1'b1;
      address    = 3;
      writedata  = 32'h5A5A5A5A;
      byteenable = 4'hF;
      step();
      idle();
      repeat (3) step();
      rd(3, 32'h5A5A5A5A);
      repeat (3) step();

      chipselect = 1'b1;
      read       = 1'b1;
      address    = 7;
      push(32'h11BB33DD, 3);
      step();
      idle();
      clken = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("wait stall", wait1, 1'b1);
         @(posedge clk);
         #1;
      end
      clken = 1'b1;
      repeat (4) step();

      chipselect = 1'b1;
      read       = 1'b1;
      address    = 1;
      push(32'h10000001, 0);
      step();
      reset_req = 1'b1;
      address   = 2;
      @(negedge clk);
      chk("wait reset_req", wait2, 1'b1);
      step();
      step();
      idle();
      reset_req = 1'b0;
      repeat (4) step();

      wr(9, 32'hCAFEF00D, 4'hF);
      repeat (4) step();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      repeat (8) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      count_wait("wait after pulse");
      step();
      rd(9, EXP9);

      begin
         int t = 0;
         while ((q1.size() != 0 || q2.size() != 0) && t < 50) begin
            step();
            t++;
         end
      end
      step();
      chk("q1 drained", q1.size(), 0);
      chk("q2 drained", q2.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/qsys_system_onchip_memory3.md
QSYS_SYSTEM_ONCHIP_MEMORY3 -- requirements
Module: qsys_system_onchip_memory3

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data width in bits, a multiple of 8, from 8 to 128.
REQ-002 The block SHALL have parameter ADDR_W, default 10: word address width; depth DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1: cycles from read acceptance to readdatavalid; legal values 1 or 2.
REQ-004 The block SHALL have parameter INIT_FILE, default "qsys_system_onchip_memory3.hex": power-up contents file.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 address  input  ADDR_W  word address.
REQ-008 byteenable  input  DATA_W/8  byte-lane write enables.
REQ-009 chipselect  input  1  slave select.
REQ-010 read  input  1  read request.
REQ-011 write  input  1  write request.
REQ-012 writedata  input  DATA_W  write data.
REQ-013 clken  input  1  clock enable; low freezes the block.
REQ-014 reset_req  input  1  memory-protect request; high blocks all accesses.
REQ-015 waitrequest  output  1  high: request not accepted this cycle.
REQ-016 readdata  output  DATA_W  read data, valid only with readdatavalid.
REQ-017 readdatavalid  output  1  one-cycle pulse per accepted read.

Function
REQ-018 waitrequest SHALL equal (~clken | reset_req | clearing), combinationally; clearing is defined in REQ-030.
REQ-019 A request SHALL be accepted on a rising edge where chipselect=1, waitrequest=0 and read or write=1.
REQ-020 An accepted write SHALL update only the byte lanes with byteenable[i]=1; lanes with byteenable[i]=0 SHALL keep their prior value.
REQ-021 Simultaneous read=1 and write=1 SHALL be treated as a write only; no readdatavalid SHALL be generated for it.
REQ-022 An accepted read at cycle N SHALL assert readdatavalid for exactly one cycle at N+READ_LATENCY, with readdata valid in that same cycle.
REQ-023 Reads SHALL be pipelined: one read per cycle with no bubbles; responses SHALL return in request order.
REQ-024 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-025 When clken=0, the read pipeline (valid bits and data) SHALL hold. A pending readdatavalid SHALL be held until the cycle after clken returns high, and SHALL be emitted exactly once.
REQ-026 reset_req=1 SHALL block new accesses; reads already in flight SHALL still complete normally.
REQ-027 readdata SHALL be zero whenever readdatavalid=0.
REQ-028 Out-of-range address SHALL NOT occur; the address width equals the array depth.

Reset
REQ-029 While reset_n=0: readdatavalid=0, readdata=0, pipeline valid bits=0, and waitrequest=1 (clearing forced). Memory array contents SHALL be unaffected by reset unless REQ-031 applies.
REQ-030 clearing SHALL be a one-bit state (IDLE/CLEAR). It SHALL be forced high during reset and SHALL exit to IDLE on the first clk edge after reset_n rises, unless REQ-031 applies.

Configuration
REQ-031 With ONCHIP_MEM3_CLEAR_EN defined, a clear engine SHALL operate as follows:
- After reset_n deasserts, the FSM stays in CLEAR and writes all-zero words to addresses 0..DEPTH-1, one per cycle while clken=1.
- The clear engine pauses when clken=0.
- The FSM enters IDLE after the DEPTH-1 write; waitrequest stays 1 for exactly DEPTH clken-enabled cycles.
- Reset reasserted mid-clear restarts the sweep from address 0.
REQ-032 Without ONCHIP_MEM3_CLEAR_EN, the clear engine SHALL NOT be generated; the array SHALL hold INIT_FILE contents after configuration, and REQ-030 SHALL apply.

Verification
REQ-033 Defaults, no macro: write 0xDEADBEEF to addr 5 with be=0xF, then read addr 5 -> readdatavalid one cycle after read acceptance, readdata=0xDEADBEEF.
REQ-034 Write 0x11223344 to addr 7 with be=0xF, then 0xAABBCCDD with be=0x5, then read addr 7 -> readdata=0x11BB33DD.
REQ-035 READ_LATENCY=2: back-to-back reads of addrs 1,2,3 -> three consecutive readdatavalid pulses starting 2 cycles after the first acceptance, data in order.
REQ-036 A read is accepted, then clken drops for 3 cycles -> readdatavalid is withheld, then emitted once in the cycle after clken returns high; waitrequest=1 during the stall.
REQ-037 ONCHIP_MEM3_CLEAR_EN, ADDR_W=4: release reset -> waitrequest=1 for 16 cycles. A read of addr 9 afterwards returns 0. Pulsing reset_n low at clear cycle 8 -> a full 16-cycle sweep restarts.
REQ-038 Read and write asserted together to addr 3 with data 0x5A5A5A5A -> no readdatavalid; a later read of addr 3 returns 0x5A5A5A5A.
